// File: rtl/turbo_stream_checker_pkg.sv
// Shared types and trellis helpers for the turbo stream checker.
// The RSC state is packed {s1,s2,s3}, so s1 is bit 2 and s3 is bit 0.
package turbo_pkg;

    localparam int TAIL_CYCLES = 4;
    localparam int LEN_W_DEF   = 9;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        TAIL0,
        TAIL1,
        TAIL2,
        TAIL3,
        DONE
    } state_e;

    typedef logic [2:0] rsc_state_t;

    // One trellis step of the LTE constituent code: returns {next_state, z}.
    function automatic logic [3:0] rsc_step(input rsc_state_t s, input logic u);
        logic fb;
        fb = u ^ s[1] ^ s[0];
        return {fb, s[2], s[1], fb ^ s[2] ^ s[0]};
    endfunction

    // Expected encoder-1 tail for a data-end state:
    // {x_K, z_K, x_K1, z_K1, x_K2, z_K2}.
    function automatic logic [5:0] rsc_tail(input rsc_state_t s);
        return {s[1] ^ s[0], s[2] ^ s[0], s[2] ^ s[1], s[1], s[2], s[2]};
    endfunction

endpackage

// File: rtl/turbo_stream_checker_if.sv
// Serial link from the turbo encoder plus the checker's result signals.
interface turbo_stream_checker_if #(
    parameter int LEN_W = 9
);
    logic [LEN_W-1:0] length;
    logic             look_now;
    logic             xk;
    logic             zk;
    logic             zkp;
    logic             ck_out;
    logic             zkp_out;
    logic             out_valid;
    logic             frame_done;
    logic             parity_err;
    logic             term_err;
    logic             len_err;
    logic [LEN_W-1:0] err_count;
    logic [5:0]       tail_p;

    // Encoder side: drives the link, observes results.
    modport master (
        output length, look_now, xk, zk, zkp,
        input  ck_out, zkp_out, out_valid, frame_done,
        input  parity_err, term_err, len_err, err_count, tail_p
    );

    // Checker side.
    modport slave (
        input  length, look_now, xk, zk, zkp,
        output ck_out, zkp_out, out_valid, frame_done,
        output parity_err, term_err, len_err, err_count, tail_p
    );
endinterface

// File: rtl/turbo_stream_checker_rsc.sv
// Local copy of the encoder-1 RSC, driven by the received systematic bits.
// clr_i makes the current step start from the all-zero state, so the first
// bit of a frame is re-encoded in the same cycle the state is cleared.
module rsc_reencoder
    import turbo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       u_i,
    output rsc_state_t state_o,
    output logic       z_o
);
    rsc_state_t state_q;
    rsc_state_t state_cur;
    logic [3:0] step;

    // Select the starting state and evaluate one trellis step.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_cur = state_q;
        if (clr_i) begin
            state_cur = '0;
        end
        step = rsc_step(state_cur, u_i);
    end

    assign z_o     = step[0];
    assign state_o = state_q;

    // Advance on enabled data bits; hold through the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
            state_q <= '0;
        end else if (en_i) begin
            state_q <= step[3:1];
        end else if (clr_i) begin
            state_q <= '0;
        end
    end
endmodule

// File: rtl/turbo_stream_checker.sv
// Turbo stream receive checker: forwards ck/zkp, checks zk parity and the
// encoder-1 termination against a local re-encoder, captures encoder-2 tail.
module turbo_stream_checker
    import turbo_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    turbo_stream_checker_if.slave bus
);
    state_e           state_q;
    logic [LEN_W-1:0] k_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] err_count_q;
    logic [LEN_W-1:0] err_count_d;
    logic             ck_q;
    logic             zkp_q;
    logic             out_valid_q;
    logic             frame_done_q;
    logic             parity_err_q;
    logic             term_err_q;
    logic             len_err_q;
    logic             x_k1_q;
    logic [5:0]       tail_p_q;

    rsc_state_t       rsc_state;
    logic             exp_z;
    logic             frame_start;
    logic             rsc_en;
    logic             z_mis;
    logic             t0_bad;
    logic             t1_bad;
    logic [5:0]       exp_tail;

    assign frame_start = (state_q == IDLE) && bus.look_now;
    assign rsc_en      = frame_start || ((state_q == DATA) && bus.look_now);

    rsc_reencoder u_rsc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (frame_start),
        .en_i    (rsc_en),
        .u_i     (bus.xk),
        .state_o (rsc_state),
        .z_o     (exp_z)
    );

    // The re-encoder state is frozen after the data phase, so it is the data-end state in the tail.
    assign exp_tail    = rsc_tail(rsc_state);
    assign z_mis       = (bus.zk != exp_z);
    assign t0_bad      = (bus.xk != exp_tail[5]) || (bus.zk != exp_tail[4]);
    assign t1_bad      = (bus.xk != exp_tail[2]) || (bus.zk != exp_tail[1]) ||
                         (bus.zkp != exp_tail[0]) || (x_k1_q != exp_tail[3]);
    assign cnt_d       = cnt_q + 1'b1;
    assign err_count_d = (z_mis && (err_count_q != '1)) ? err_count_q + 1'b1 : err_count_q;

    // Frame FSM with registered outputs, counters, checks and tail capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            cnt_q        <= '0;
            err_count_q  <= '0;
            ck_q         <= 1'b0;
            zkp_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            term_err_q   <= 1'b0;
            len_err_q    <= 1'b0;
            x_k1_q       <= 1'b0;
            tail_p_q     <= '0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.look_now) begin
                        k_q          <= bus.length;
                        cnt_q        <= LEN_W'(1);
                        ck_q         <= bus.xk;
                        zkp_q        <= bus.zkp;
                        out_valid_q  <= 1'b1;
                        parity_err_q <= z_mis;
                        err_count_q  <= {{(LEN_W-1){1'b0}}, z_mis};
                        term_err_q   <= 1'b0;
                        len_err_q    <= (bus.length == '0);
                        tail_p_q     <= '0;
                        state_q      <= (bus.length <= LEN_W'(1)) ? TAIL0 : DATA;
                    end
                end
                DATA: begin
                    if (bus.look_now) begin
                        ck_q        <= bus.xk;
                        zkp_q       <= bus.zkp;
                        out_valid_q <= 1'b1;
                        cnt_q       <= cnt_d;
                        err_count_q <= err_count_d;
                        if (z_mis) begin
                            parity_err_q <= 1'b1;
                        end
                        if (cnt_d == k_q) begin
                            state_q <= TAIL0;
                        end
                    end else begin
                        // Early drop: this cycle already carries the first tail bits.
                        len_err_q <= 1'b1;
                        x_k1_q    <= bus.zkp;
                        if (t0_bad) begin
                            term_err_q <= 1'b1;
                        end
                        state_q <= TAIL1;
                    end
                end
                TAIL0: begin
                    x_k1_q <= bus.zkp;
                    if (t0_bad) begin
                        term_err_q <= 1'b1;
                    end
                    state_q <= TAIL1;
                end
                TAIL1: begin
                    if (t1_bad) begin
                        term_err_q <= 1'b1;
                    end
                    state_q <= TAIL2;
                end
                TAIL2: begin
                    tail_p_q[5:3] <= {bus.xk, bus.zk, bus.zkp};
                    state_q       <= TAIL3;
                end
                TAIL3: begin
                    tail_p_q[2:0] <= {bus.xk, bus.zk, bus.zkp};
                    state_q       <= DONE;
                end
                DONE: begin
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ck_out     = ck_q;
    assign bus.zkp_out    = zkp_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.term_err   = term_err_q;
    assign bus.len_err    = len_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.tail_p     = tail_p_q;
endmodule

// File: tb/tb_turbo_stream_checker.sv
// Self-checking bench for turbo_stream_checker: frames are built from a
// polynomial-level encoder model and replayed cycle by cycle on the link.
module tb_turbo_stream_checker;

    localparam int LW = 9;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    // Driven link lines and the clean reference frame, indexed by cycle.
    bit dx [0:127];
    bit dz [0:127];
    bit dp [0:127];
    bit rx [0:127];
    bit rz [0:127];
    bit rp [0:127];

    turbo_stream_checker_if #(.LEN_W(LW)) bus ();

    turbo_stream_checker #(.LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of data bits the checker consumes for a given length and look_now run.
    function automatic int data_len(input int k, input int l);
        if (k <= 1) return 1;
        return (l < k) ? l : k;
    endfunction

    // Reference encoder: a_k = u_k + a_{k-2} + a_{k-3}, z_k = a_k + a_{k-1} + a_{k-3}.
    // Termination feeds the register's own feedback back so it flushes to zero.
    task automatic encode(input int n);
        bit a1, a2, a3, a;
        bit tx [0:2];
        bit tz [0:2];
        a1 = 0; a2 = 0; a3 = 0;
        for (int i = 0; i < n; i++) begin
            a     = dx[i] ^ a2 ^ a3;
            dz[i] = a ^ a1 ^ a3;
            a3 = a2; a2 = a1; a1 = a;
        end
        for (int t = 0; t < 3; t++) begin
            tx[t] = a2 ^ a3;
            tz[t] = a1 ^ a3;
            a3 = a2; a2 = a1; a1 = 0;
        end
        dx[n] = tx[0]; dz[n] = tz[0]; dp[n] = tx[1];
        dx[n+1] = tz[1]; dz[n+1] = tx[2]; dp[n+1] = tz[2];
    endtask

    task automatic save_ref();
        for (int i = 0; i < 128; i++) begin
            rx[i] = dx[i]; rz[i] = dz[i]; rp[i] = dp[i];
        end
    endtask

    // Clean frame with n data bits; random (or all-zero) payload and encoder-2 lines.
    task automatic prep_frame(input int n, input bit zero);
        for (int i = 0; i < 128; i++) begin
            dx[i] = zero ? 1'b0 : 1'($urandom_range(0, 1));
            dz[i] = zero ? 1'b0 : 1'($urandom_range(0, 1));
            dp[i] = zero ? 1'b0 : 1'($urandom_range(0, 1));
        end
        encode(n);
        save_ref();
    endtask

    task automatic drive_cycle(input int i, input int k, input int l);
        bus.length   = LW'(k);
        bus.look_now = (i < l);
        bus.xk       = dx[i];
        bus.zk       = dz[i];
        bus.zkp      = dp[i];
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bus.look_now = 1'b0;
            @(posedge clk); #1;
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle: out_valid=%b frame_done=%b, required 0 0", bus.out_valid, bus.frame_done);
            end
        end
    endtask

    // Replays the prepared frame and checks it against the reference frame.
    task automatic run_frame(input string name, input int k, input int l);
        int n, perr;
        bit exp_v, exp_term, exp_len;
        logic [5:0] exp_tp;
        n = data_len(k, l);
        perr = 0;
        for (int i = 0; i < n; i++) if (dz[i] != rz[i]) perr++;
        exp_term = 0;
        for (int i = n; i < n + 2; i++)
            if (dx[i] != rx[i] || dz[i] != rz[i] || dp[i] != rp[i]) exp_term = 1;
        exp_len = (k == 0) || (k >= 2 && l < k);
        exp_tp  = {dx[n+2], dz[n+2], dp[n+2], dx[n+3], dz[n+3], dp[n+3]};
        for (int i = 0; i <= n + 4; i++) begin
            drive_cycle(i, k, l);
            @(posedge clk); #1;
            exp_v = (i < n);
            tests_run++;
            if (bus.out_valid !== exp_v || bus.frame_done !== (i == n + 4)) begin
                tests_failed++;
                $display("FAIL %s timing cycle %0d: valid/done=%b%b, required %b%b",
                         name, i, bus.out_valid, bus.frame_done, exp_v, (i == n + 4));
            end
            if (exp_v) begin
                tests_run++;
                if ({bus.ck_out, bus.zkp_out} !== {dx[i], dp[i]}) begin
                    tests_failed++;
                    $display("FAIL %s data bit %0d: ck/zkp=%b%b, required %b%b",
                             name, i, bus.ck_out, bus.zkp_out, dx[i], dp[i]);
                end
            end
        end
        tests_run++;
        if (bus.parity_err !== (perr != 0) || bus.err_count !== LW'(perr)) begin
            tests_failed++;
            $display("FAIL %s parity: parity_err=%b err_count=%0d, required %b %0d",
                     name, bus.parity_err, bus.err_count, (perr != 0), perr);
        end
        tests_run++;
        if (bus.term_err !== exp_term) begin
            tests_failed++;
            $display("FAIL %s term_err: %b, required %b", name, bus.term_err, exp_term);
        end
        tests_run++;
        if (bus.len_err !== exp_len) begin
            tests_failed++;
            $display("FAIL %s len_err: %b, required %b", name, bus.len_err, exp_len);
        end
        tests_run++;
        if (bus.tail_p !== exp_tp) begin
            tests_failed++;
            $display("FAIL %s tail_p: %b, required %b", name, bus.tail_p, exp_tp);
        end
        bus.look_now = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({bus.ck_out, bus.zkp_out, bus.out_valid, bus.frame_done, bus.parity_err,
             bus.term_err, bus.len_err} !== 7'b0 || bus.err_count !== '0 || bus.tail_p !== '0) begin
            tests_failed++;
            $display("FAIL %s: outputs ck,zkp,valid,done,perr,terr,lerr=%b%b%b%b%b%b%b cnt=%0d tail=%b, required all 0",
                     name, bus.ck_out, bus.zkp_out, bus.out_valid, bus.frame_done, bus.parity_err,
                     bus.term_err, bus.len_err, bus.err_count, bus.tail_p);
        end
    endtask

    // Directed length-4 frame: xk=1000 gives zk=1111 and tail 110/111.
    task automatic prep_vec4();
        prep_frame(4, 1'b1);
        dx[0] = 1'b1;
        encode(4);
        {dx[6], dz[6], dp[6]} = 3'b101;
        {dx[7], dz[7], dp[7]} = 3'b011;
        save_ref();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cycle(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_zero_frame();
        prep_frame(40, 1'b1);
        run_frame("zero40", 40, 40);
        idle(2);
    endtask

    task automatic test_vec4();
        prep_vec4();
        tests_run++;
        if ({dz[0], dz[1], dz[2], dz[3]} != 4'b1111 || {dx[4], dz[4], dp[4], dx[5], dz[5], dp[5]} != 6'b110111) begin
            tests_failed++;
            $display("FAIL vec4 model: z=%b%b%b%b, required 1111", dz[0], dz[1], dz[2], dz[3]);
        end
        run_frame("vec4", 4, 4);
        tests_run++;
        if (bus.tail_p !== 6'b101011 || bus.parity_err !== 1'b0 || bus.term_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL vec4 flags: tail_p=%b perr=%b terr=%b, required 101011 0 0",
                     bus.tail_p, bus.parity_err, bus.term_err);
        end
        idle(2);
        prep_vec4();
        dz[2] = 1'b0;
        run_frame("vec4_zflip", 4, 4);
        idle(2);
        prep_vec4();
        dp[5] = 1'b0;
        run_frame("vec4_tailflip", 4, 4);
        idle(2);
    endtask

    task automatic test_len();
        prep_frame(6, 1'b0);
        run_frame("len_early", 10, 6);
        idle(2);
        prep_frame(1, 1'b0);
        run_frame("len_zero", 0, 1);
        idle(2);
        prep_frame(1, 1'b0);
        run_frame("len_one", 1, 3);
        idle(2);
    endtask

    task automatic test_random();
        int k, l, n, sel;
        for (int f = 0; f < 12; f++) begin
            k   = $urandom_range(2, 60);
            sel = $urandom_range(0, 3);
            if (sel == 0)      l = $urandom_range(1, k - 1);
            else if (sel == 1) l = k + $urandom_range(1, 6);
            else               l = k;
            n = data_len(k, l);
            prep_frame(n, 1'b0);
            if ($urandom_range(0, 1) == 1)
                for (int e = 0; e < int'($urandom_range(1, 3)); e++) begin
                    sel = $urandom_range(0, n - 1);
                    dz[sel] = ~dz[sel];
                end
            if ($urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 5);
                case (sel % 3)
                    0: dx[n + sel / 3] = ~dx[n + sel / 3];
                    1: dz[n + sel / 3] = ~dz[n + sel / 3];
                    default: dp[n + sel / 3] = ~dp[n + sel / 3];
                endcase
            end
            run_frame($sformatf("rand%0d", f), k, l);
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        prep_frame(5, 1'b0);
        dz[1] = ~dz[1];
        run_frame("b2b_a", 5, 5);
        prep_frame(7, 1'b0);
        run_frame("b2b_b", 7, 7);
        prep_frame(3, 1'b0);
        run_frame("b2b_c", 3, 3);
        idle(2);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 8;
        prep_frame(n, 1'b0);
        dz[2] = ~dz[2];
        for (int i = 0; i <= n; i++) begin
            drive_cycle(i, n, n);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        @(posedge clk); #1;
        check_all_zero("reset_mid_hold");
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        prep_vec4();
        run_frame("after_reset", 4, 4);
        idle(2);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_zero_frame();
        test_vec4();
        test_len();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/turbo_stream_checker.md
Name: turbo_stream_checker

Overview:
- Receive end of the turbo encoder's three serial output lines (xk, zk, zkp) plus its look_now strobe.
- Recover systematic bits ck and forward the interleaved parity zkp.
- Re-encode xk through a local LTE constituent RSC (g0=1+D^2+D^3, g1=1+D+D^3) to check zk parity and encoder-1 trellis termination, assuming a noiseless link.
- Capture encoder-2 tail bits for software/bench inspection; used as an on-chip loopback checker and as the front end of a future iterative decoder.

Parameters:
LEN_W, 9, width of length input and bit counters.
TAIL_CYCLES, 4, tail cycles following the data phase; fixed, not configurable in practice.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
length  in  LEN_W  frame length K; sampled on first look_now cycle.
look_now  in  1  high while xk/zk/zkp carry data bits.
xk  in  1  systematic / tail line d0.
zk  in  1  parity-1 / tail line d1.
zkp  in  1  parity-2 / tail line d2.
ck_out  out  1  recovered systematic bit.
zkp_out  out  1  forwarded parity-2 bit.
out_valid  out  1  ck_out/zkp_out valid.
frame_done  out  1  one-cycle pulse at end of frame.
parity_err  out  1  sticky per frame: any zk mismatch.
term_err  out  1  sticky per frame: encoder-1 tail mismatch.
len_err  out  1  sticky per frame: look_now fell early or length==0.
err_count  out  LEN_W  zk mismatch count, saturating.
tail_p  out  6  encoder-2 tail bits {T2 xk,zk,zkp, T3 xk,zk,zkp}.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; RSC state (s1,s2,s3) = 000. Reset mid-frame aborts the frame with no frame_done.
- FSM states: IDLE, DATA, TAIL0, TAIL1, TAIL2, TAIL3, DONE.
- IDLE:
  - On look_now=1: latch length into K_r and clear parity_err, term_err, len_err, err_count, tail_p and RSC state.
  - Process the current bit as bit 0 with cnt=1.
  - Go to DATA, or to TAIL0 if length==1 or length==0. length==0 also sets len_err.
- DATA bit processing, per cycle with u=xk:
  - fb = u^s2^s3; expected z = fb^s1^s3.
  - Next state (s1,s2,s3) = (fb,s1,s2).
  - If zk != expected z: set parity_err and increment err_count (saturating).
- Registered outputs, latency 1: ck_out=xk, zkp_out=zkp, out_valid=1. out_valid is 0 in all other states.
- DATA transitions:
  - cnt reaching K_r -> TAIL0 on the next cycle.
  - look_now=0 while cnt<K_r -> set len_err, treat the current cycle as TAIL0, and evaluate it as such.
  - look_now staying high past K_r is ignored; the line is treated as tail.
- Termination check: with data-end state (s1,s2,s3), the expected encoder-1 tail is:
  - x_K=s2^s3, z_K=s1^s3
  - x_K1=s1^s2, z_K1=s2
  - x_K2=s1, z_K2=s1
- TAIL0: compare xk to x_K, zk to z_K. Store zkp as x_K1. Go to TAIL1.
- TAIL1: compare xk to z_K1, zk to x_K2, zkp to z_K2, and the stored bit to x_K1. Any mismatch in TAIL0/TAIL1 sets term_err. Go to TAIL2.
- TAIL2, TAIL3: capture xk,zk,zkp into tail_p, MSB first. No check. Go to TAIL3, then DONE.
- DONE: frame_done=1 for one cycle; error flags and tail_p remain valid until the next frame starts. Return to IDLE.
- look_now asserted in any TAIL state or in DONE is ignored; a new frame may start in IDLE on the cycle after DONE.

Decomposition:
- turbo_pkg holds:
  - state enum
  - TAIL_CYCLES=4
  - LEN_W default
  - function rsc_step(state,u) returning {next_state,z}
  - function rsc_tail(state) returning the 6 expected tail bits
- One sub-module, rsc_reencoder, holds the 3-bit state register with clear/enable and outputs the expected z.
- turbo_stream_checker contains the FSM, counters, compare logic and capture registers.

Test Plan:
- length=40, look_now high 40 cycles, all lines 0, then 4 tail cycles of 0 -> 40 out_valid cycles with ck_out=0, frame_done at cycle 46 after the first look_now, all error flags 0, err_count=0.
- length=4, xk=1,0,0,0, zk=1,1,1,1 -> ck_out 1,0,0,0 with no parity_err. Tail TAIL0 (xk,zk,zkp)=(1,1,0), TAIL1=(1,1,1), TAIL2/TAIL3 arbitrary 101,011 -> term_err=0, tail_p=6'b101011.
- Same frame with zk bit 2 flipped to 0 -> parity_err=1, err_count=1, term_err=0.
- Same frame with TAIL1 zkp=0 -> term_err=1, parity_err=0.
- length=10, look_now drops after 6 cycles -> len_err=1, TAIL0 evaluated on cycle 7, frame_done 4 cycles later.
- rst asserted during TAIL1 -> all outputs 0 immediately, no frame_done; the next frame (length=4 vector above) checks clean.
